// File: rtl/instr_fetch.sv
// instr_fetch: IF stage owning the PC, one outstanding req/ack fetch, single-entry skid buffer toward decode
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_ce
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
    state_t      state;
    logic [31:0] pc, skid_instr, skid_pc;
    logic        discard;

    assign o_imem_req  = (state == S_WAIT);
    assign o_imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            o_ce    <= 1'b0;
            o_instr <= NOP_INSTR;
            o_pc    <= RESET_PC;
            discard <= 1'b0;
        end else if (i_flush) begin
            pc      <= i_branch_pc & ~32'd3;
            o_ce    <= 1'b0;
            o_instr <= NOP_INSTR;
            state   <= S_WAIT;
            // a request left unanswered now belongs to the killed path
            discard <= o_imem_req && !i_imem_ack;
        end else begin
            if (o_ce && !i_stall) begin
                o_ce    <= 1'b0;
                o_instr <= NOP_INSTR;
            end
            case (state)
                S_IDLE: state <= S_WAIT;
                S_WAIT: if (i_imem_ack) begin
                    if (discard) discard <= 1'b0;
                    else begin
                        pc <= pc + 32'd4;
                        if (i_stall && o_ce) begin
                            skid_instr <= i_imem_data;
                            skid_pc    <= pc;
                            state      <= S_HOLD;
                        end else begin
                            o_instr <= i_imem_data;
                            o_pc    <= pc;
                            o_ce    <= 1'b1;
                        end
                    end
                end
                default: if (!i_stall) begin
                    o_instr <= skid_instr;
                    o_pc    <= skid_pc;
                    o_ce    <= 1'b1;
                    state   <= S_WAIT;
                end
            endcase
        end
    end
endmodule
